// File: rtl/decode_pkg.sv
// Shared definitions for the decode RAM write stage.
// bank_addr forms a RAM address with the bank select above the in-bank offset.
package decode_pkg;

  localparam int ASIZE_DEF = 10;
  localparam int BANK_AW   = ASIZE_DEF - 1;

  function automatic logic [31:0] bank_addr(input logic bank, input logic [31:0] offset, input int aw);
    return ({31'b0, bank} << aw) | offset;
  endfunction

endpackage

// File: rtl/decode_frame_loader.sv
// Ping-pong frame writer for the decode RAM: packs a valid/ready word stream into two banks
// and hands each closed frame (bank, length) to the downstream reader.
module decode_frame_loader
  import decode_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 10,
  parameter int FRAME_LEN = 2 ** (ASIZE - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [ASIZE-1:0] addrc,
  output logic [DSIZE-1:0] dinc,
  output logic             wec,
  output logic             frame_valid,
  output logic             rd_bank,
  output logic [ASIZE-1:0] frame_len,
  input  logic             frame_release
);

  localparam int BW = ASIZE - 1;

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [BW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic [ASIZE-1:0] len_q [2];
  logic [ASIZE-1:0] len_d [2];
  logic             frame_valid_q, frame_valid_d;
  logic [ASIZE-1:0] addrc_q, addrc_d;
  logic [DSIZE-1:0] dinc_q, dinc_d;
  logic             wec_q, wec_d;

  logic accept;
  logic close;
  logic rel_fire;

  assign s_ready  = ~rst & ~bank_full_q[wr_bank_q];
  assign accept   = s_valid & s_ready;
  assign close    = accept & (s_last | (wr_ptr_q == BW'(FRAME_LEN - 1)));
  assign rel_fire = frame_release & frame_valid_q;

  always_comb begin
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_ptr_d      = wr_ptr_q;
    bank_full_d   = bank_full_q;
    len_d         = len_q;
    addrc_d       = addrc_q;
    dinc_d        = dinc_q;
    wec_d         = 1'b0;
    // Presentation lags a close by one edge, so the final RAM write lands before the reader starts.
    frame_valid_d = bank_full_q[rd_bank_q] & ~frame_release;

    if (accept) begin
      addrc_d = ASIZE'(bank_addr(wr_bank_q, 32'(wr_ptr_q), BW));
      dinc_d  = s_data;
      wec_d   = 1'b1;
      if (close) begin
        bank_full_d[wr_bank_q] = 1'b1;
        len_d[wr_bank_q]       = ASIZE'({1'b0, wr_ptr_q}) + ASIZE'(1);
        wr_bank_d              = ~wr_bank_q;
        wr_ptr_d               = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + BW'(1);
      end
    end

    // A release always targets the bank opposite any concurrent close, so both updates can apply.
    if (rel_fire) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      bank_full_q   <= 2'b00;
      len_q[0]      <= '0;
      len_q[1]      <= '0;
      frame_valid_q <= 1'b0;
      addrc_q       <= '0;
      dinc_q        <= '0;
      wec_q         <= 1'b0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      bank_full_q   <= bank_full_d;
      len_q[0]      <= len_d[0];
      len_q[1]      <= len_d[1];
      frame_valid_q <= frame_valid_d;
      addrc_q       <= addrc_d;
      dinc_q        <= dinc_d;
      wec_q         <= wec_d;
    end
  end

  assign addrc       = addrc_q;
  assign dinc        = dinc_q;
  assign wec         = wec_q;
  assign frame_valid = frame_valid_q;
  assign rd_bank     = rd_bank_q;
  assign frame_len   = len_q[rd_bank_q];

endmodule
